// File: rtl/rca_response_checker.sv
// Response checker for the ripple-carry adder: recomputes {cout,sum}, counts mismatches and builds a MISR signature.
// Optional build macro RCA_CHK_STOP_ON_ERR_EN: end the run on the first mismatch.
module rca_response_checker #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_W     = 16,
  parameter logic [31:0] MISR_POLY = 32'h0040_0007,
  parameter logic [31:0] MISR_SEED = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] vec_count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [31:0]      signature
);

  localparam int unsigned RespW = WIDTH + 1;
  localparam int unsigned SigW  = 32;

`ifdef RCA_CHK_STOP_ON_ERR_EN
  localparam bit StopOnErr = 1'b1;
`else
  localparam bit StopOnErr = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic               s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]   s1_a_q, s1_a_d;
  logic [WIDTH-1:0]   s1_b_q, s1_b_d;
  logic               s1_cin_q, s1_cin_d;
  logic [WIDTH-1:0]   s1_sum_q, s1_sum_d;
  logic               s1_cout_q, s1_cout_d;
  logic [CNT_W-1:0]   s1_idx_q, s1_idx_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   first_q, first_d;
  logic [SigW-1:0]    sig_q, sig_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               in_ready_q, in_ready_d;

  logic [RespW-1:0]   exp_c;
  logic [RespW-1:0]   obs_c;
  logic               mismatch_c;
  logic               last_c;
  logic               stop_c;
  logic               xfer_c;
  logic [CNT_W-1:0]   err_next_c;
  logic [SigW-1:0]    sig_next_c;

  // Stage-2 compare of the vector held in stage 1
  assign exp_c      = RespW'(s1_a_q) + RespW'(s1_b_q) + RespW'(s1_cin_q);
  assign obs_c      = {s1_cout_q, s1_sum_q};
  assign mismatch_c = s1_valid_q && (obs_c != exp_c);
  assign last_c     = s1_valid_q && (s1_idx_q == (vec_q - CNT_W'(1)));
  assign stop_c     = StopOnErr && mismatch_c;
  assign err_next_c = !mismatch_c ? err_q :
                      ((err_q == {CNT_W{1'b1}}) ? err_q : err_q + CNT_W'(1));
  assign sig_next_c = ({sig_q[SigW-2:0], 1'b0} ^ (sig_q[SigW-1] ? MISR_POLY : '0))
                      ^ SigW'(obs_c);

  // A mismatch about to stop the run blocks the handshake in the same cycle
  assign in_ready = in_ready_q && !stop_c;
  assign xfer_c   = in_valid && in_ready;

  assign busy          = (state_q == CHECK);
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_idx = first_q;
  assign signature     = sig_q;

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    acc_d      = acc_q;
    s1_valid_d = 1'b0;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_cin_d   = s1_cin_q;
    s1_sum_d   = s1_sum_q;
    s1_cout_d  = s1_cout_q;
    s1_idx_d   = s1_idx_q;
    err_d      = err_q;
    first_d    = first_q;
    sig_d      = sig_q;
    done_d     = done_q;
    pass_d     = pass_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          vec_d   = vec_count;
          acc_d   = '0;
          err_d   = '0;
          first_d = '1;
          sig_d   = MISR_SEED;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          if (vec_count == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (xfer_c) begin
          s1_valid_d = 1'b1;
          s1_a_d     = in_a;
          s1_b_d     = in_b;
          s1_cin_d   = in_cin;
          s1_sum_d   = in_sum;
          s1_cout_d  = in_cout;
          s1_idx_d   = acc_q;
          acc_d      = acc_q + CNT_W'(1);
        end
        if (s1_valid_q) begin
          err_d = err_next_c;
          sig_d = sig_next_c;
          if (mismatch_c && (first_q == {CNT_W{1'b1}})) begin
            first_d = s1_idx_q;
          end
          if (last_c || stop_c) begin
            state_d    = DONE;
            done_d     = 1'b1;
            pass_d     = (err_next_c == '0);
            s1_valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == CHECK) && (acc_d < vec_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      acc_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_cin_q   <= 1'b0;
      s1_sum_q   <= '0;
      s1_cout_q  <= 1'b0;
      s1_idx_q   <= '0;
      err_q      <= '0;
      first_q    <= '1;
      sig_q      <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      acc_q      <= acc_d;
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_cin_q   <= s1_cin_d;
      s1_sum_q   <= s1_sum_d;
      s1_cout_q  <= s1_cout_d;
      s1_idx_q   <= s1_idx_d;
      err_q      <= err_d;
      first_q    <= first_d;
      sig_q      <= sig_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_rca_response_checker.sv
// Directed bench for rca_response_checker with hand-picked vectors and a small MISR model.
module tb_rca_response_checker;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] vec_count;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_cin;
  logic [7:0]  in_sum;
  logic        in_cout;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic [15:0] first_err_idx;
  logic [31:0] signature;

  int n_checks = 0;
  int n_fail   = 0;
  int xfers    = 0;
  int rdy_cyc  = 0;

  rca_response_checker dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .vec_count    (vec_count),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_cin       (in_cin),
    .in_sum       (in_sum),
    .in_cout      (in_cout),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err_count    (err_count),
    .first_err_idx(first_err_idx),
    .signature    (signature)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (in_valid && in_ready) xfers = xfers + 1;
    if (in_ready) rdy_cyc = rdy_cyc + 1;
  end

  function automatic logic [31:0] misr(input logic [31:0] s, input logic [8:0] d);
    return ({s[30:0], 1'b0} ^ (s[31] ? 32'h0040_0007 : 32'h0)) ^ {23'd0, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] n);
    start     = 1'b1;
    vec_count = n;
    tick();
    start     = 1'b0;
  endtask

  // Offer one vector until accepted or the cycle budget runs out
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input logic [7:0] s, input logic co, input int budget, output bit ok);
    in_valid = 1'b1;
    in_a = a; in_b = b; in_cin = ci; in_sum = s; in_cout = co;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({in_ready, busy, done, pass} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {in_ready, busy, done, pass});
    end
    n_checks++;
    if (err_count !== 16'h0000 || first_err_idx !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL reset_counts: err=%h first=%h expected 0000/ffff", err_count, first_err_idx);
    end
    n_checks++;
    if (signature !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_sig: got %h expected 00000000", signature);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_correct_stream();
    bit ok0, ok1, ok2, ok3;
    int x0;
    logic [31:0] exp_sig;
    exp_sig = misr(misr(misr(misr(32'hFFFF_FFFF, 9'h002), 9'h010), 9'h100), 9'h100);
    x0 = xfers;
    do_start(16'd4);
    send(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1, ok0);
    send(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1, ok1);
    send(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1, ok2);
    send(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1, ok3);
    n_checks++;
    if ({ok0, ok1, ok2, ok3} !== 4'b1111 || (xfers - x0) != 4) begin
      n_fail++;
      $display("FAIL b2b_xfers: accepted=%b count=%0d expected 1111/4", {ok0, ok1, ok2, ok3}, xfers - x0);
    end
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_early_done: done=%b busy=%b expected 0/1", done, busy);
    end
    tick();
    n_checks++;
    if ({done, pass, busy} !== 3'b110 || err_count !== 16'd0 || first_err_idx !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL b2b_result: done/pass/busy=%b err=%h first=%h expected 110/0000/ffff",
               {done, pass, busy}, err_count, first_err_idx);
    end
    n_checks++;
    if (signature !== exp_sig) begin
      n_fail++;
      $display("FAIL b2b_sig: got %h expected %h", signature, exp_sig);
    end
  endtask

  task automatic test_error_stream();
    bit ok0, ok1, ok2, ok3;
    int x0;
    logic [31:0] exp_sig;
    x0 = xfers;
    do_start(16'd4);
    send(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1, ok0);
    send(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1, ok1);
    send(8'hFF, 8'h01, 1'b0, 8'h01, 1'b1, 1, ok2);
`ifdef RCA_CHK_STOP_ON_ERR_EN
    send(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 4, ok3);
    exp_sig = misr(misr(misr(32'hFFFF_FFFF, 9'h002), 9'h010), 9'h101);
    n_checks++;
    if ({ok0, ok1, ok2, ok3} !== 4'b1110 || (xfers - x0) != 3) begin
      n_fail++;
      $display("FAIL err_stop_xfers: accepted=%b count=%0d expected 1110/3", {ok0, ok1, ok2, ok3}, xfers - x0);
    end
`else
    send(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1, ok3);
    tick();
    exp_sig = misr(misr(misr(misr(32'hFFFF_FFFF, 9'h002), 9'h010), 9'h101), 9'h100);
    n_checks++;
    if ({ok0, ok1, ok2, ok3} !== 4'b1111 || (xfers - x0) != 4) begin
      n_fail++;
      $display("FAIL err_xfers: accepted=%b count=%0d expected 1111/4", {ok0, ok1, ok2, ok3}, xfers - x0);
    end
`endif
    n_checks++;
    if ({done, pass} !== 2'b10 || err_count !== 16'd1 || first_err_idx !== 16'd2) begin
      n_fail++;
      $display("FAIL err_result: done/pass=%b err=%h first=%h expected 10/0001/0002",
               {done, pass}, err_count, first_err_idx);
    end
    n_checks++;
    if (signature !== exp_sig) begin
      n_fail++;
      $display("FAIL err_sig: got %h expected %h", signature, exp_sig);
    end
  endtask

  task automatic test_zero_count();
    int r0;
    r0 = rdy_cyc;
    do_start(16'd0);
    n_checks++;
    if ({done, pass, busy} !== 3'b110 || signature !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL zero_result: done/pass/busy=%b sig=%h expected 110/ffffffff", {done, pass, busy}, signature);
    end
    tick();
    tick();
    n_checks++;
    if ((rdy_cyc - r0) != 0) begin
      n_fail++;
      $display("FAIL zero_ready: ready cycles=%0d expected 0", rdy_cyc - r0);
    end
  endtask

  task automatic test_gapped();
    int x0;
    logic [31:0] exp_sig;
    exp_sig = misr(misr(32'hFFFF_FFFF, 9'h002), 9'h010);
    x0 = xfers;
    do_start(16'd2);
    in_valid = 1'b1;
    in_a = 8'h01; in_b = 8'h01; in_cin = 1'b0; in_sum = 8'h02; in_cout = 1'b0;
    tick();
    in_valid = 1'b0;
    start = 1'b1;
    vec_count = 16'd7;
    tick();
    start = 1'b0;
    tick();
    in_valid = 1'b1;
    in_a = 8'h0F; in_b = 8'h01; in_cin = 1'b0; in_sum = 8'h10; in_cout = 1'b0;
    tick();
    in_a = 8'h33; in_b = 8'h11; in_cin = 1'b0; in_sum = 8'h99; in_cout = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    n_checks++;
    if ((xfers - x0) != 2 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_xfers: count=%0d ready=%b expected 2/0", xfers - x0, in_ready);
    end
    in_valid = 1'b0;
    n_checks++;
    if ({done, pass, busy} !== 3'b110 || err_count !== 16'd0 || signature !== exp_sig) begin
      n_fail++;
      $display("FAIL gap_result: done/pass/busy=%b err=%h sig=%h expected 110/0000/%h",
               {done, pass, busy}, err_count, signature, exp_sig);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok0, ok1, ok2;
    logic [31:0] exp_sig;
    exp_sig = misr(32'hFFFF_FFFF, 9'h002);
    do_start(16'd4);
    send(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1, ok0);
    send(8'hFF, 8'h01, 1'b0, 8'h05, 1'b0, 1, ok1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if ({in_ready, busy, done, pass} !== 4'b0000 || err_count !== 16'd0 ||
        first_err_idx !== 16'hFFFF || signature !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_state: flags=%b err=%h first=%h sig=%h expected 0000/0000/ffff/00000000",
               {in_ready, busy, done, pass}, err_count, first_err_idx, signature);
    end
    do_start(16'd1);
    send(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 2, ok2);
    tick();
    n_checks++;
    if (!ok2 || {done, pass} !== 2'b11 || signature !== exp_sig) begin
      n_fail++;
      $display("FAIL midrst_rerun: ok=%b done/pass=%b sig=%h expected 1/11/%h",
               ok2, {done, pass}, signature, exp_sig);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; vec_count = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sum = '0; in_cout = 1'b0;
    test_reset();
    test_correct_stream();
    test_error_stream();
    test_zero_count();
    test_gapped();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
